// File: rtl/ws2812_rx_pkg.sv
// Shared types and default timing values for the WS2812 line receiver.
// Defaults assume a 10 MHz system clock.
package ws2812_rx_pkg;

    localparam int DEF_T_THRESH     = 6;
    localparam int DEF_MIN_HIGH     = 2;
    localparam int DEF_RESET_CYCLES = 500;
    localparam int DEF_IDX_W        = 8;
    localparam int PIXEL_W          = 24;

    // One decoded pixel in wire order: green first, blue last.
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } rx_state_t;

    // Build the finished pixel from the 23 bits already collected plus the final bit.
    function automatic pixel_t assemble_pixel(input logic [PIXEL_W-2:0] head, input logic last_bit);
        return pixel_t'({head, last_bit});
    endfunction

endpackage

// File: rtl/ws2812_rx_sync_edge.sv
// Two-flop synchronizer for an asynchronous line input, followed by a
// registered rise/fall strobe generator. Strobes lag the pin by 3 cycles.
module led_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic rise_r;
    logic fall_r;

    // Metastability filter, previous-level history and registered edge strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            rise_r  <= sync2_r & ~prev_r;
            fall_r  <= ~sync2_r & prev_r;
        end
    end

    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 NRZ receiver: measures high-pulse widths, assembles 24-bit GRB
// pixels, detects the latch gap and presents pixels on a valid/ready port.
module ws2812_rx
    import ws2812_rx_pkg::*;
#(
    parameter int T_THRESH     = DEF_T_THRESH,
    parameter int MIN_HIGH     = DEF_MIN_HIGH,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int IDX_W        = DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    output logic [23:0]      pixel_data,
    output logic             pixel_valid,
    input  logic             pixel_ready,
    output logic [IDX_W-1:0] pixel_index,
    output logic             frame_end,
    output logic             overflow
);

    localparam int HC_W = $clog2(T_THRESH + 1);
    localparam int LC_W = $clog2(RESET_CYCLES + 1);

    logic             rise_s;
    logic             fall_s;
    rx_state_t        state_r;
    rx_state_t        state_next_s;
    rx_state_t        prev_low_r;
    logic [HC_W-1:0]  high_cnt_r;
    logic [LC_W-1:0]  low_cnt_r;
    logic [4:0]       bit_cnt_r;
    logic [22:0]      shift_r;
    logic [IDX_W-1:0] frame_idx_r;
    pixel_t           pixel_data_r;
    logic             pixel_valid_r;
    logic [IDX_W-1:0] pixel_index_r;
    logic             frame_end_r;
    logic             overflow_r;

    logic short_pulse_s;
    logic gap_reached_s;
    logic bit_val_s;
    logic bit_done_s;
    logic gap_s;
    logic high_start_s;
    logic high_run_s;
    logic low_run_s;
    logic pix_done_s;

    led_sync_edge u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (din),
        .rise  (rise_s),
        .fall  (fall_s)
    );

    assign short_pulse_s = (high_cnt_r < HC_W'(MIN_HIGH));
    assign gap_reached_s = (low_cnt_r == LC_W'(RESET_CYCLES));
    assign bit_val_s     = (high_cnt_r >= HC_W'(T_THRESH));
    assign pix_done_s    = bit_done_s && (bit_cnt_r == 5'd23);

    // FSM state register; remembers which low state a pulse started from so a glitch can return there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            prev_low_r <= IDLE;
        end else begin
            state_r <= state_next_s;
            if (high_start_s) begin
                prev_low_r <= state_r;
            end
        end
    end

    // FSM next-state logic; a rise coinciding with the gap still starts the next pulse.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (rise_s) state_next_s = HIGH;
                else        state_next_s = IDLE;
            end
            HIGH: begin
                if (fall_s) begin
                    if (short_pulse_s) state_next_s = prev_low_r;
                    else               state_next_s = LOW;
                end else begin
                    state_next_s = HIGH;
                end
            end
            LOW: begin
                if (rise_s)             state_next_s = HIGH;
                else if (gap_reached_s) state_next_s = IDLE;
                else                    state_next_s = LOW;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: counter enables, bit acceptance and latch-gap detection.
    always_comb begin
        bit_done_s   = 1'b0;
        gap_s        = 1'b0;
        high_start_s = 1'b0;
        high_run_s   = 1'b0;
        low_run_s    = 1'b0;
        case (state_r)
            IDLE: begin
                high_start_s = rise_s;
            end
            HIGH: begin
                bit_done_s = fall_s & ~short_pulse_s;
                high_run_s = ~fall_s;
            end
            LOW: begin
                gap_s        = gap_reached_s;
                high_start_s = rise_s;
                low_run_s    = ~gap_reached_s;
            end
            default: begin
                bit_done_s   = 1'b0;
                gap_s        = 1'b0;
            end
        endcase
    end

    // High-pulse width counter; counts sampled high cycles, saturating at the 1-bit threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_cnt_r <= {HC_W{1'b0}};
        end else if (high_start_s) begin
            high_cnt_r <= HC_W'(1);
        end else if (high_run_s && !bit_val_s) begin
            high_cnt_r <= high_cnt_r + HC_W'(1);
        end else begin
            high_cnt_r <= high_cnt_r;
        end
    end

    // Low-time counter; frozen across a high pulse so a rejected glitch does not disturb the gap count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_cnt_r <= {LC_W{1'b0}};
        end else if (gap_s || bit_done_s) begin
            low_cnt_r <= {LC_W{1'b0}};
        end else if (low_run_s) begin
            low_cnt_r <= low_cnt_r + LC_W'(1);
        end else begin
            low_cnt_r <= low_cnt_r;
        end
    end

    // Bit assembly; the latch gap discards any partial pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r <= 5'd0;
            shift_r   <= 23'd0;
        end else if (gap_s) begin
            bit_cnt_r <= 5'd0;
        end else if (bit_done_s) begin
            shift_r   <= {shift_r[21:0], bit_val_s};
            bit_cnt_r <= pix_done_s ? 5'd0 : (bit_cnt_r + 5'd1);
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Running pixel position within the frame; advances even for dropped pixels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_idx_r <= {IDX_W{1'b0}};
        end else if (pix_done_s) begin
            frame_idx_r <= frame_idx_r + IDX_W'(1);
        end else if (gap_s) begin
            frame_idx_r <= {IDX_W{1'b0}};
        end else begin
            frame_idx_r <= frame_idx_r;
        end
    end

    // Output holding register with valid/ready handshake and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_data_r  <= pixel_t'(24'd0);
            pixel_valid_r <= 1'b0;
            pixel_index_r <= {IDX_W{1'b0}};
            frame_end_r   <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            frame_end_r <= gap_s;
            if (pix_done_s) begin
                if (!pixel_valid_r || pixel_ready) begin
                    pixel_data_r  <= assemble_pixel(shift_r, bit_val_s);
                    pixel_valid_r <= 1'b1;
                    pixel_index_r <= frame_idx_r;
                end else begin
                    overflow_r <= 1'b1;
                end
            end else if (pixel_valid_r && pixel_ready) begin
                pixel_valid_r <= 1'b0;
            end else begin
                pixel_valid_r <= pixel_valid_r;
            end
        end
    end

    assign pixel_data  = pixel_data_r;
    assign pixel_valid = pixel_valid_r;
    assign pixel_index = pixel_index_r;
    assign frame_end   = frame_end_r;
    assign overflow    = overflow_r;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed self-checking bench for ws2812_rx: table of pixels plus
// hand-written sequences for backpressure, glitch, partial frame and reset.
module tb_ws2812_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       din;
    logic       pixel_ready;
    logic [23:0] pixel_data;
    logic       pixel_valid;
    logic [7:0] pixel_index;
    logic       frame_end;
    logic       overflow;

    ws2812_rx dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .pixel_data  (pixel_data),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .pixel_index (pixel_index),
        .frame_end   (frame_end),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor state, updated on the falling edge.
    int         cyc = 0;
    int         acc_cnt = 0;
    int         valid_rises = 0;
    int         valid_rise_cyc = 0;
    int         fe_pulses = 0;
    int         fe_cycles = 0;
    int         fall_cyc = 0;
    logic [23:0] last_data = 24'd0;
    logic [7:0]  last_idx = 8'd0;
    logic        prev_valid = 1'b0;
    logic        prev_fe = 1'b0;

    typedef struct {
        logic [23:0] pix;
        logic [7:0]  idx;
        logic        gap;
    } vec_t;

    vec_t vecs[5];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pixel_valid && pixel_ready) begin
            acc_cnt   <= acc_cnt + 1;
            last_data <= pixel_data;
            last_idx  <= pixel_index;
        end
        if (pixel_valid && !prev_valid) begin
            valid_rises    <= valid_rises + 1;
            valid_rise_cyc <= cyc;
        end
        if (frame_end) fe_cycles <= fe_cycles + 1;
        if (frame_end && !prev_fe) fe_pulses <= fe_pulses + 1;
        prev_valid <= pixel_valid;
        prev_fe    <= frame_end;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One bit: 12-cycle period, T1H = 8, T0H = 4; optional 1-cycle glitch in a 0-bit low phase.
    task automatic send_bit(input logic b, input logic glitch);
        int th;
        th = b ? 8 : 4;
        din = 1'b1;
        repeat (th) @(posedge clk);
        #1;
        din = 1'b0;
        fall_cyc = cyc;
        if (glitch && !b) begin
            repeat (3) @(posedge clk);
            #1 din = 1'b1;
            @(posedge clk);
            #1 din = 1'b0;
            repeat (12 - th - 4) @(posedge clk);
            #1;
        end else begin
            repeat (12 - th) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [23:0] pix, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            send_bit(pix[23 - i], i == glitch_bit);
        end
    endtask

    task automatic idle(input int n);
        din = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, v0, f0, c0;

        vecs[0] = '{24'h12AB34, 8'd0, 1'b1};
        vecs[1] = '{24'hFF0000, 8'd0, 1'b0};
        vecs[2] = '{24'h00FF00, 8'd1, 1'b0};
        vecs[3] = '{24'h0000FF, 8'd2, 1'b1};
        vecs[4] = '{24'hA5C3E7, 8'd0, 1'b1};

        // Reset held with the line toggling.
        rst_n = 1'b0;
        din = 1'b0;
        pixel_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 din = ~din;
        end
        check("reset_data", 32'(pixel_data), 0);
        check("reset_ctrl", 32'({pixel_valid, frame_end, overflow}), 0);
        check("reset_index", 32'(pixel_index), 0);
        din = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(50);
        check("post_reset_valid_rises", valid_rises, 0);
        check("post_reset_frame_end", fe_pulses, 0);

        // Table: single pixel, a three-pixel frame, and the first pixel of the next frame.
        for (int i = 0; i < 5; i++) begin
            a0 = acc_cnt; v0 = valid_rises; f0 = fe_pulses; c0 = fe_cycles;
            send_bits(vecs[i].pix, 24, -1);
            idle(6);
            check("vec_accepts", acc_cnt - a0, 1);
            check("vec_valid_pulses", valid_rises - v0, 1);
            check("vec_data", 32'(last_data), 32'(vecs[i].pix));
            check("vec_index", 32'(last_idx), 32'(vecs[i].idx));
            check("vec_latency", valid_rise_cyc - fall_cyc, 4);
            if (vecs[i].gap) begin
                idle(600);
                check("vec_frame_end_pulses", fe_pulses - f0, 1);
                check("vec_frame_end_width", fe_cycles - c0, 1);
            end else begin
                check("vec_no_frame_end", fe_pulses - f0, 0);
            end
        end
        check("overflow_clear", 32'(overflow), 0);

        // Backpressure: two pixels with the consumer stalled.
        pixel_ready = 1'b0;
        a0 = acc_cnt; v0 = valid_rises;
        send_bits(24'h0F1E2D, 24, -1);
        send_bits(24'h3C4B5A, 24, -1);
        idle(6);
        check("bp_valid", 32'(pixel_valid), 1);
        check("bp_data_held", 32'(pixel_data), 32'h0F1E2D);
        check("bp_index_held", 32'(pixel_index), 0);
        check("bp_overflow", 32'(overflow), 1);
        check("bp_no_accept", acc_cnt - a0, 0);
        check("bp_single_rise", valid_rises - v0, 1);
        pixel_ready = 1'b1;
        @(posedge clk);
        #1 pixel_ready = 1'b0;
        idle(2);
        check("bp_accepted", acc_cnt - a0, 1);
        check("bp_accepted_data", 32'(last_data), 32'h0F1E2D);
        check("bp_valid_dropped", 32'(pixel_valid), 0);
        check("bp_overflow_sticky", 32'(overflow), 1);
        idle(600);
        pixel_ready = 1'b1;

        // Glitch: a 1-cycle high pulse inside the low phase of bit 10.
        a0 = acc_cnt;
        send_bits(24'h5A5A5A, 24, 10);
        idle(6);
        check("glitch_accepts", acc_cnt - a0, 1);
        check("glitch_data", 32'(last_data), 32'h5A5A5A);
        check("glitch_index", 32'(last_idx), 0);
        idle(600);

        // Partial frame: 10 bits then the latch gap.
        a0 = acc_cnt; v0 = valid_rises; f0 = fe_pulses;
        send_bits(24'hFFC000, 10, -1);
        idle(600);
        check("partial_frame_end", fe_pulses - f0, 1);
        check("partial_no_pixel", valid_rises - v0, 0);
        send_bits(24'h13579B, 24, -1);
        idle(6);
        check("after_partial_accepts", acc_cnt - a0, 1);
        check("after_partial_data", 32'(last_data), 32'h13579B);
        check("after_partial_index", 32'(last_idx), 0);

        // Reset in the middle of a pixel.
        send_bits(24'hC0FFEE, 12, -1);
        rst_n = 1'b0;
        #2;
        check("midrst_data", 32'(pixel_data), 0);
        check("midrst_ctrl", 32'({pixel_valid, frame_end, overflow}), 0);
        check("midrst_index", 32'(pixel_index), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);
        a0 = acc_cnt;
        send_bits(24'h2468AC, 24, -1);
        idle(6);
        check("after_rst_accepts", acc_cnt - a0, 1);
        check("after_rst_data", 32'(last_data), 32'h2468AC);
        check("after_rst_index", 32'(last_idx), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Single-wire NRZ pulse-stream receiver and decoder for the serial LED data line driven by the LED matrix driver. It recovers 24-bit GRB pixels from pulse widths and detects the latch (reset) gap that ends a frame. Decoded pixels are presented on a valid/ready interface. It sits as a loopback checker on the driver output, and it also serves as the input stage of a daisy-chained matrix tile.

## Interface

Parameters:
- T_THRESH, 6: high-pulse length in cycles at or above which a bit decodes as 1. At 10 MHz, T0H is about 4 cycles and T1H about 8.
- MIN_HIGH, 2: high pulses shorter than this are glitches and are ignored.
- RESET_CYCLES, 500: consecutive low cycles that constitute the latch gap (50 µs at 10 MHz).
- IDX_W, 8: width of pixel_index.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  1  raw serial LED line, asynchronous to clk.
- pixel_data  out  24  decoded pixel {G[7:0], R[7:0], B[7:0]}, MSB first on the wire.
- pixel_valid  out  1  pixel_data holds an unconsumed pixel.
- pixel_ready  in  1  consumer accepts the pixel when pixel_valid && pixel_ready.
- pixel_index  out  IDX_W  position within the frame of the pixel on pixel_data.
- frame_end  out  1  one-cycle pulse when the latch gap is detected.
- overflow  out  1  sticky flag: a pixel was dropped because the output register was full.

## Operation

- din passes through a 2-FF synchronizer and then an edge detector that produces rise and fall strobes on din_s.
- State machine:
  - IDLE: line low, bit count 0. A rise moves to HIGH.
  - HIGH: high_cnt increments each cycle, saturating at T_THRESH.
    - On a fall with high_cnt < MIN_HIGH: the pulse is ignored and the state returns to the previous low state (IDLE or LOW) with low_cnt preserved.
    - On any other fall: the bit is decoded as (high_cnt >= T_THRESH), shifted into the 24-bit shift register, bit_cnt increments, and the state moves to LOW.
  - LOW: low_cnt increments each cycle, saturating at RESET_CYCLES.
    - A rise moves to HIGH and clears low_cnt.
    - When low_cnt reaches RESET_CYCLES: frame_end pulses, partial bits are discarded (bit_cnt cleared), the frame index is cleared, and the state moves to IDLE.
- When bit_cnt reaches 24, the pixel completes and bit_cnt returns to 0:
  - If the output register is empty, or is being accepted in the same cycle: load pixel_data and set pixel_valid. pixel_index takes the running frame index, which then increments with wrap-around.
  - Otherwise: drop the new pixel, keep the old one, set overflow, and still increment the frame index.
- If frame_end and pixel completion coincide, completion is processed first. This case cannot occur for legal streams, but it must not corrupt state.
- overflow clears only on reset.

## Timing

- Reset values:
  - pixel_data = 0, pixel_valid = 0, pixel_index = 0, frame_end = 0, overflow = 0.
  - State IDLE; all counters 0; synchronizer flops 0.
- Latency from the din edge to detection is 2 cycles (synchronizer) plus 1 cycle (edge register).
- pixel_valid rises 1 cycle after the falling-edge strobe of the 24th bit, which is 4 cycles after the din pin falls.
- frame_end pulses 1 cycle after low_cnt reaches RESET_CYCLES. It is high for exactly 1 cycle and is independent of pixel_ready.
- Handshake:
  - pixel_data and pixel_index hold stable while pixel_valid is high and pixel_ready is low.
  - pixel_valid drops the cycle after acceptance unless a new pixel loads in that same cycle.
- A reset assertion mid-pixel or mid-frame clears everything immediately (asynchronously). The first pixel after reset release is decoded only from the first full 24 bits seen.

## Structure

- Package ws2812_rx_pkg:
  - pixel_t (24-bit packed struct g, r, b).
  - State enum rx_state_t {IDLE, HIGH, LOW}.
  - Default localparams for the 10 MHz timing values.
- One sub-module, led_sync_edge: 2-FF synchronizer plus rise/fall strobe generator. It is reusable by other line-input blocks.

## Test plan

- Reset: hold rst_n = 0 with din toggling → all outputs stay 0. Release → no pixel_valid without a stream.
- Single pixel: drive 24 bits of 0x12AB34 (T0H = 4, T1H = 8, period 12 cycles), pixel_ready = 1 → pixel_valid pulses once with pixel_data = 0x12AB34 and pixel_index = 0, 4 cycles after the last din fall.
- Frame of 3 pixels (0xFF0000, 0x00FF00, 0x0000FF) followed by 500 low cycles → indices 0, 1, 2; frame_end pulses once. The next frame starts at index 0.
- Backpressure: pixel_ready = 0 for 2 pixels → the first pixel is held, overflow = 1, and pixel_index reads 0. Raising pixel_ready consumes that first pixel.
- Glitch and partial frame: a 1-cycle high pulse mid-stream is ignored and the decoded pixel is unaffected. Sending 10 bits then a 500-cycle gap → frame_end pulses, no pixel is emitted, and the next 24 bits decode cleanly.
- Reset mid-pixel: assert rst_n low after 12 bits → outputs return to reset values. A following full pixel decodes correctly.
